// File: rtl/inst_seq.sv
// Host-side instruction sequencer: turns a start pulse plus a K/Q vector stream into one
// full attention pass for fullchip. Optional macro INST_SEQ_PERF_CNT_EN adds a busy-cycle counter.
module inst_seq #(
    parameter int col       = 8,
    parameter int bw        = 8,
    parameter int pr        = 16,
    parameter int depth     = 16,
    parameter int drain_cyc = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [pr*bw-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [18:0]         inst,
    output logic [pr*bw-1:0]    mem_out,
    output logic                busy,
`ifdef INST_SEQ_PERF_CNT_EN
    output logic                done,
    output logic [31:0]         cycle_cnt
`else
    output logic                done
`endif
);

    localparam int B_QMEM_RD  = 4;
    localparam int B_QMEM_WR  = 5;
    localparam int B_KMEM_RD  = 6;
    localparam int B_KMEM_WR  = 7;
    localparam int B_LOAD     = 8;
    localparam int B_EXECUTE  = 9;
    localparam int B_OFIFO_RD = 10;
    localparam int B_PMEM_WR  = 16;

    localparam logic [15:0] COL_LAST   = 16'(col - 1);
    localparam logic [15:0] DEPTH_LAST = 16'(depth - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(drain_cyc - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_K, S_WR_Q, S_LOAD, S_EXEC, S_DRAIN, S_READ, S_DONE
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [15:0]         cnt_r, cnt_nxt_s;
    logic [18:0]         inst_r, inst_nxt_s;
    logic [pr*bw-1:0]    mem_out_r, mem_nxt_s;
    logic                busy_r, done_r, in_ready_r;

    assign inst     = inst_r;
    assign mem_out  = mem_out_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign in_ready = in_ready_r;

    // Next-state, phase counter and next instruction word; cnt restarts at 0 on every state entry.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        inst_nxt_s  = 19'd0;
        mem_nxt_s   = mem_out_r;
        case (state_r)
            S_IDLE: begin
                cnt_nxt_s = 16'd0;
                if (start) begin
                    state_nxt_s = S_WR_K;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WR_K, S_WR_Q: begin
                if (in_valid) begin
                    inst_nxt_s[3:0] = cnt_r[3:0];
                    mem_nxt_s       = in_data;
                    if (state_r == S_WR_K) begin
                        inst_nxt_s[B_KMEM_WR] = 1'b1;
                    end else begin
                        inst_nxt_s[B_QMEM_WR] = 1'b1;
                    end
                    if (state_r == S_WR_K && cnt_r == COL_LAST) begin
                        state_nxt_s = S_WR_Q;
                        cnt_nxt_s   = 16'd0;
                    end else if (state_r == S_WR_Q && cnt_r == DEPTH_LAST) begin
                        state_nxt_s = S_LOAD;
                        cnt_nxt_s   = 16'd0;
                    end else begin
                        cnt_nxt_s = cnt_r + 16'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            S_LOAD: begin
                inst_nxt_s[3:0]       = cnt_r[3:0];
                inst_nxt_s[B_KMEM_RD] = 1'b1;
                inst_nxt_s[B_LOAD]    = 1'b1;
                if (cnt_r == COL_LAST) begin
                    state_nxt_s = S_EXEC;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            S_EXEC: begin
                inst_nxt_s[3:0]       = cnt_r[3:0];
                inst_nxt_s[B_QMEM_RD] = 1'b1;
                inst_nxt_s[B_EXECUTE] = 1'b1;
                if (cnt_r == DEPTH_LAST) begin
                    state_nxt_s = S_DRAIN;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    state_nxt_s = S_READ;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            S_READ: begin
                inst_nxt_s[14:11]      = cnt_r[3:0];
                inst_nxt_s[B_OFIFO_RD] = 1'b1;
                inst_nxt_s[B_PMEM_WR]  = 1'b1;
                if (cnt_r == DEPTH_LAST) begin
                    state_nxt_s = S_DONE;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = 16'd0;
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = 16'd0;
            end
        endcase
    end

    // State, counter and registered outputs; status flags track the next state so they match the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= 16'd0;
            inst_r     <= 19'd0;
            mem_out_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            inst_r     <= inst_nxt_s;
            mem_out_r  <= mem_nxt_s;
            busy_r     <= (state_nxt_s != S_IDLE);
            done_r     <= (state_nxt_s == S_DONE);
            in_ready_r <= (state_nxt_s == S_WR_K) || (state_nxt_s == S_WR_Q);
        end
    end

`ifdef INST_SEQ_PERF_CNT_EN
    // Busy-cycle counter: cleared when a start is accepted, held after the pass ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
        end else if (state_r == S_IDLE && start) begin
            cycle_cnt <= 32'd0;
        end else if (state_r != S_IDLE) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end else begin
            cycle_cnt <= cycle_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_inst_seq.sv
// Self-checking bench for inst_seq: a per-pass expected instruction list is built from the
// pass rules and the chosen valid/data pattern, then compared cycle by cycle.
module tb_inst_seq;
    localparam int COL   = 8;
    localparam int BW    = 8;
    localparam int PR    = 16;
    localparam int DEPTH = 16;
    localparam int DRAIN = 10;
    localparam int DW    = PR * BW;
    localparam int NMAX  = 256;

    if (COL > 16 || DEPTH > 16) begin : g_bad_param
        initial begin
            $display("FAIL param_range: col=%0d depth=%0d must be <= 16", COL, DEPTH);
            $fatal(1, "bad parameters");
        end
    end

    logic           clk = 1'b0;
    logic           reset, start, in_valid, in_ready, busy, done;
    logic [DW-1:0]  in_data, mem_out;
    logic [18:0]    inst;
`ifdef INST_SEQ_PERF_CNT_EN
    logic [31:0]    cycle_cnt;
`endif

    always #5 clk = ~clk;

    inst_seq #(.col(COL), .bw(BW), .pr(PR), .depth(DEPTH), .drain_cyc(DRAIN)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .inst(inst), .mem_out(mem_out), .busy(busy),
`ifdef INST_SEQ_PERF_CNT_EN
        .done(done), .cycle_cnt(cycle_cnt)
`else
        .done(done)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    bit             vpat [NMAX];
    logic [DW-1:0]  dpat [NMAX];
    logic [18:0]    e_inst[$];
    logic [DW-1:0]  e_mem[$];
    logic [DW-1:0]  mem_prev = '0;
    int             cc_prev  = 0;

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < DW; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Expected per-cycle inst/mem_out list of one pass, starting with the inst visible in cycle 2.
    task automatic build_expect(output int l_done, output int w_end);
        int words = 0;
        int c = 1;
        logic [DW-1:0] last = mem_prev;
        e_inst.delete();
        e_mem.delete();
        while (words < COL + DEPTH && c < NMAX - 80) begin
            if (vpat[c]) begin
                if (words < COL) e_inst.push_back(19'h00080 | 19'(words & 15));
                else             e_inst.push_back(19'h00020 | 19'((words - COL) & 15));
                last = dpat[c];
                words++;
            end else begin
                e_inst.push_back(19'h0);
            end
            e_mem.push_back(last);
            c++;
        end
        w_end = c - 1;
        for (int i = 0; i < COL; i++)   begin e_inst.push_back(19'h00140 | 19'(i & 15)); e_mem.push_back(last); end
        for (int i = 0; i < DEPTH; i++) begin e_inst.push_back(19'h00210 | 19'(i & 15)); e_mem.push_back(last); end
        for (int i = 0; i < DRAIN; i++) begin e_inst.push_back(19'h0); e_mem.push_back(last); end
        for (int i = 0; i < DEPTH; i++) begin e_inst.push_back(19'h10400 | (19'(i & 15) << 11)); e_mem.push_back(last); end
        l_done = 1 + e_inst.size();
    endtask

    task automatic pat_fill(input int mode);
        for (int c = 0; c < NMAX; c++) begin
            dpat[c] = rand_vec();
            case (mode)
                0: vpat[c] = 1'b1;
                1: vpat[c] = !(c >= 5 && c <= 7);
                default: vpat[c] = (c >= 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 0 && c >= 1 && c <= COL)              dpat[c] = DW'(c - 1);
            if (mode == 0 && c > COL && c <= COL + DEPTH)     dpat[c] = DW'(c - 1 - COL);
        end
    endtask

    // One pass from start in cycle 0; s1/s2 extra start pulses (s2 < 0 means the done cycle); abort_at > 0 resets there.
    task automatic run_pass(input string name, input int s1, input int s2, input int abort_at);
        int l_done, w_end, sz, s2_eff;
        logic [DW-1:0] exp_mem;
        logic [18:0]   exp_inst;
        build_expect(l_done, w_end);
        sz = e_inst.size();
        s2_eff = (s2 < 0) ? l_done : s2;
        for (int c = 0; c <= l_done + 3; c++) begin
            @(negedge clk);
            if (abort_at > 0 && c == abort_at + 1) begin
                check_val($sformatf("%s_abort_inst", name), DW'(inst), '0);
                check_val($sformatf("%s_abort_busy", name), DW'(busy), '0);
                check_val($sformatf("%s_abort_done", name), DW'(done), '0);
                check_val($sformatf("%s_abort_rdy", name), DW'(in_ready), '0);
                check_val($sformatf("%s_abort_mem", name), mem_out, '0);
`ifdef INST_SEQ_PERF_CNT_EN
                check_val($sformatf("%s_abort_cc", name), DW'(cycle_cnt), '0);
`endif
                reset = 1'b0; start = 1'b0; in_valid = 1'b0;
                mem_prev = '0; cc_prev = 0;
                return;
            end
            exp_inst = (c >= 2 && c - 2 < sz) ? e_inst[c - 2] : 19'h0;
            exp_mem  = (c < 2) ? mem_prev : ((c - 2 < sz) ? e_mem[c - 2] : e_mem[sz - 1]);
            check_val($sformatf("%s_inst_c%0d", name, c), DW'(inst), DW'(exp_inst));
            check_val($sformatf("%s_mem_c%0d", name, c), mem_out, exp_mem);
            check_val($sformatf("%s_busy_c%0d", name, c), DW'(busy), DW'(c >= 1 && c <= l_done));
            check_val($sformatf("%s_done_c%0d", name, c), DW'(done), DW'(c == l_done));
            check_val($sformatf("%s_rdy_c%0d", name, c), DW'(in_ready), DW'(c >= 1 && c <= w_end));
`ifdef INST_SEQ_PERF_CNT_EN
            check_val($sformatf("%s_cc_c%0d", name, c), DW'(cycle_cnt),
                      DW'((c == 0) ? cc_prev : ((c - 1 < l_done) ? c - 1 : l_done)));
`endif
            start    = (c == 0) || (c == s1) || (c == s2_eff);
            in_valid = vpat[c];
            in_data  = dpat[c];
            reset    = (abort_at > 0 && c == abort_at);
        end
        start = 1'b0; in_valid = 1'b0;
        mem_prev = e_mem[sz - 1];
        cc_prev  = l_done;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val($sformatf("idle_inst_%0d", i), DW'(inst), '0);
            check_val($sformatf("idle_mem_%0d", i), mem_out, '0);
            check_val($sformatf("idle_busy_%0d", i), DW'(busy), '0);
            check_val($sformatf("idle_done_%0d", i), DW'(done), '0);
            check_val($sformatf("idle_rdy_%0d", i), DW'(in_ready), '0);
`ifdef INST_SEQ_PERF_CNT_EN
            check_val($sformatf("idle_cc_%0d", i), DW'(cycle_cnt), '0);
`endif
        end
        pat_fill(0); run_pass("clean", -1, 0, 0);
        pat_fill(1); run_pass("stall3", -1, 0, 0);
        pat_fill(0); run_pass("restart", 10, -1, 0);
        pat_fill(0); run_pass("abort", -1, 0, 40);
        pat_fill(0); run_pass("after_abort", -1, 0, 0);
        for (int r = 0; r < 4; r++) begin
            pat_fill(2);
            run_pass($sformatf("rand%0d", r), 10, -1, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
